// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (d = a - b, LSB first) with one full-subtractor cell and a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sa_reg, sb_reg, sd_reg;
    logic [WIDTH-1:0]   sa_next, sb_next, sd_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               br_reg;
    logic [WIDTH-1:0]   d_reg;
    logic               borrow_reg;
    logic               busy_reg, done_reg;
    logic               accept, last_step;
    logic               x, y, bin, diff_bit, bout;

    assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_step = (state_reg == RUN) && (cnt_reg == CNT_LAST);

    // Single full-subtractor cell operating on the current LSBs.
    assign x        = sa_reg[0];
    assign y        = sb_reg[0];
    assign bin      = br_reg;
    assign diff_bit = x ^ y ^ bin;
    assign bout     = (~x & y) | (~(x ^ y) & bin);

    // Right-shift wiring: operands shift in zeros, the result shifts in the new diff bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign sa_next[gi] = sa_reg[gi+1];
            assign sb_next[gi] = sb_reg[gi+1];
            assign sd_next[gi] = sd_reg[gi+1];
        end
    endgenerate
    assign sa_next[WIDTH-1] = 1'b0;
    assign sb_next[WIDTH-1] = 1'b0;
    assign sd_next[WIDTH-1] = diff_bit;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            busy_reg   <= (state_next == RUN);
            done_reg   <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_reg     <= '0;
            sb_reg     <= '0;
            sd_reg     <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            d_reg      <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            sa_reg  <= a;
            sb_reg  <= b;
            sd_reg  <= '0;
            br_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            sa_reg  <= sa_next;
            sb_reg  <= sb_next;
            sd_reg  <= sd_next;
            br_reg  <= bout;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_step) begin
                d_reg      <= sd_next;
                borrow_reg <= bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg, ovf_reg;

    // On the last step y is the subtrahend MSB and diff_bit is the result MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
        end else if (last_step) begin
            ovf_reg <= (a_msb_reg != y) && (diff_bit != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign d      = d_reg;
    assign borrow = borrow_reg;

endmodule
